// File: rtl/fsm_ncycles_high_multi.sv
// Multi-channel trigger-to-window generator: each trigger opens a window of
// programmable length on y[i], optionally followed by a lockout gap.
module fsm_ncycles_high_multi #(
    parameter int unsigned CHANNELS   = 4,
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned GAP_CYCLES = 0,
    parameter bit          EDGE_MODE  = 1'b0,
    parameter bit          RETRIGGER  = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [CHANNELS-1:0] x,
    input  logic [CNT_W-1:0]    len,
    output logic [CHANNELS-1:0] y,
    output logic [CHANNELS-1:0] done,
    output logic                busy
);

    typedef enum logic [1:0] {StIdle, StHigh, StGap} state_e;

    localparam logic [CNT_W-1:0] GapLoad = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;

    state_e              state_q [CHANNELS];
    state_e              state_d [CHANNELS];
    logic [CNT_W-1:0]    cnt_q   [CHANNELS];
    logic [CNT_W-1:0]    cnt_d   [CHANNELS];
    logic [CHANNELS-1:0] x_q;
    logic [CHANNELS-1:0] trig;
    logic [CHANNELS-1:0] y_q, y_d;
    logic [CHANNELS-1:0] done_q, done_d;
    logic                busy_q, busy_d;
    logic [CNT_W-1:0]    load_val;

    // len of 0 behaves as 1, so the reload value saturates at 0.
    assign load_val = (len == '0) ? '0 : len - CNT_W'(1);
    assign trig     = EDGE_MODE ? (x & ~x_q) : x;

    always_comb begin
        busy_d = 1'b0;
        for (int i = 0; i < int'(CHANNELS); i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            done_d[i]  = 1'b0;
            if (en) begin
                unique case (state_q[i])
                    StIdle: begin
                        if (trig[i]) begin
                            state_d[i] = StHigh;
                            cnt_d[i]   = load_val;
                        end
                    end
                    StHigh: begin
                        if (RETRIGGER && trig[i]) begin
                            cnt_d[i] = load_val;
                        end else if (cnt_q[i] != '0) begin
                            cnt_d[i] = cnt_q[i] - CNT_W'(1);
                        end else begin
                            done_d[i]  = 1'b1;
                            state_d[i] = (GAP_CYCLES > 0) ? StGap : StIdle;
                            cnt_d[i]   = GapLoad;
                        end
                    end
                    StGap: begin
                        if (cnt_q[i] != '0) begin
                            cnt_d[i] = cnt_q[i] - CNT_W'(1);
                        end else begin
                            state_d[i] = StIdle;
                        end
                    end
                    default: begin
                        state_d[i] = StIdle;
                        cnt_d[i]   = '0;
                    end
                endcase
            end
            y_d[i] = (state_d[i] == StHigh);
            busy_d = busy_d | (state_d[i] != StIdle);
        end
    end

    // x_q tracks x even while en=0 so edges seen during a freeze are not replayed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(CHANNELS); i++) begin
                state_q[i] <= StIdle;
                cnt_q[i]   <= '0;
            end
            x_q    <= '0;
            y_q    <= '0;
            done_q <= '0;
            busy_q <= 1'b0;
        end else begin
            for (int i = 0; i < int'(CHANNELS); i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            x_q    <= x;
            y_q    <= y_d;
            done_q <= done_d;
            busy_q <= busy_d;
        end
    end

    assign y    = y_q;
    assign done = done_q;
    assign busy = busy_q;

endmodule
